// File: rtl/fc_1.sv
// fc_1: LeNet-5 F6 layer, 120 C5 activations -> 84 Q8.8 neurons over the shared one-port BRAMs.
// Optional macro FC1_RELU_EN: clamp negative outputs to zero; otherwise store signed logits.
module fc_1 #(
    parameter int IN_NUM            = 120,
    parameter int OUT_NUM           = 84,
    parameter int RD_LAT            = 3,
    parameter int conv3_result_base = 7880,
    parameter int fc1_weights_base  = 50692,
    parameter int fc1_bias_base     = 60772,
    parameter int fc1_result_base   = 8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fc_1_en,
    input  logic [15:0] bias_weights_bram_douta,
    input  logic [15:0] result_bram_douta,
    output logic        bias_weights_bram_ena,
    output logic [15:0] bias_weights_bram_addra,
    output logic        result_bram_ena,
    output logic        result_bram_wea,
    output logic [12:0] result_bram_addra,
    output logic [15:0] result_bram_dina,
    output logic        fc_1_finish
);

    localparam int SUB_W = $clog2(RD_LAT + 1);
    localparam int NW    = $clog2(OUT_NUM + 1);
    localparam int IW    = $clog2(IN_NUM + 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RD_LAT);
    localparam logic [NW-1:0]    N_END    = NW'(OUT_NUM);
    localparam logic [IW-1:0]    I_END    = IW'(IN_NUM);

    typedef enum logic [5:0] {
        S_IDLE      = 6'b000001,
        S_CHECK     = 6'b000010,
        S_LOAD_BIAS = 6'b000100,
        S_MAC       = 6'b001000,
        S_STORE     = 6'b010000,
        S_DONE      = 6'b100000
    } state_t;

    state_t                   state_q, state_d;
    logic [NW-1:0]            neuron_q, neuron_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [SUB_W-1:0]         sub_q, sub_d;
    logic                     finish_q, finish_d;
    logic signed [39:0]       acc_q, acc_d;

    logic signed [15:0]       w_s;
    logic signed [15:0]       x_s;
    logic signed [31:0]       prod;
    logic signed [39:0]       bias_ext;
    logic [15:0]              store_data;

    // Arithmetic shift back to Q8.8, then clamp to the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [39:0] a);
        logic signed [39:0] s;
        s = a >>> 8;
        if (s > 40'sd32767) begin
            return 16'sh7FFF;
        end else if (s < -40'sd32768) begin
            return 16'sh8000;
        end else begin
            return s[15:0];
        end
    endfunction

    function automatic logic [15:0] relu(input logic signed [15:0] v);
`ifdef FC1_RELU_EN
        return v[15] ? 16'h0000 : v;
`else
        return v;
`endif
    endfunction

    assign w_s        = bias_weights_bram_douta;
    assign x_s        = result_bram_douta;
    assign prod       = 32'(w_s) * 32'(x_s);
    assign bias_ext   = {{16{bias_weights_bram_douta[15]}}, bias_weights_bram_douta, 8'h00};
    assign store_data = relu(sat16(acc_q));

    always_comb begin
        state_d  = state_q;
        neuron_d = neuron_q;
        idx_d    = idx_q;
        sub_d    = sub_q;
        acc_d    = acc_q;
        finish_d = finish_q;
        if (fc_1_en) begin
            unique case (state_q)
                S_IDLE: begin
                    neuron_d = '0;
                    idx_d    = '0;
                    sub_d    = '0;
                    acc_d    = '0;
                    finish_d = 1'b0;
                    state_d  = S_CHECK;
                end
                S_CHECK: begin
                    if (neuron_q == N_END) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = '0;
                        sub_d   = '0;
                        state_d = S_LOAD_BIAS;
                    end
                end
                S_LOAD_BIAS: begin
                    if (sub_q == SUB_LAST) begin
                        acc_d   = bias_ext;
                        sub_d   = '0;
                        state_d = S_MAC;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                S_MAC: begin
                    // One extra cycle with idx == IN_NUM lets both read enables drop before the store.
                    if (idx_q == I_END) begin
                        sub_d   = '0;
                        state_d = S_STORE;
                    end else if (sub_q == SUB_LAST) begin
                        acc_d = acc_q + 40'(prod);
                        idx_d = idx_q + IW'(1);
                        sub_d = '0;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                S_STORE: begin
                    if (sub_q == SUB_LAST) begin
                        neuron_d = neuron_q + NW'(1);
                        sub_d    = '0;
                        state_d  = S_CHECK;
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                end
                S_DONE: begin
                    finish_d = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else if (state_q == S_DONE) begin
            finish_d = 1'b0;
            state_d  = S_IDLE;
        end
    end

    // BRAM ports decode straight from the registered state so reset silences them at once.
    always_comb begin
        bias_weights_bram_ena   = 1'b0;
        bias_weights_bram_addra = '0;
        result_bram_ena         = 1'b0;
        result_bram_wea         = 1'b0;
        result_bram_addra       = '0;
        result_bram_dina        = '0;
        if (state_q == S_LOAD_BIAS) begin
            bias_weights_bram_ena   = (sub_q != SUB_LAST);
            bias_weights_bram_addra = 16'(fc1_bias_base) + 16'(neuron_q);
        end else if (state_q == S_MAC && idx_q != I_END) begin
            bias_weights_bram_ena   = (sub_q != SUB_LAST);
            bias_weights_bram_addra = 16'(fc1_weights_base) + 16'(neuron_q) * 16'(IN_NUM)
                                    + 16'(idx_q);
            result_bram_ena         = (sub_q != SUB_LAST);
            result_bram_addra       = 13'(conv3_result_base) + 13'(idx_q);
        end else if (state_q == S_STORE) begin
            result_bram_ena   = (sub_q != SUB_LAST);
            result_bram_wea   = (sub_q != SUB_LAST);
            result_bram_addra = 13'(fc1_result_base) + 13'(neuron_q);
            result_bram_dina  = store_data;
        end
    end

    assign fc_1_finish = finish_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            neuron_q <= '0;
            idx_q    <= '0;
            sub_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            neuron_q <= neuron_d;
            idx_q    <= idx_d;
            sub_q    <= sub_d;
            finish_q <= finish_d;
        end
    end

    always_ff @(posedge clk) begin
        acc_q <= acc_d;
    end

endmodule

// File: tb/tb_fc_1.sv
// tb_fc_1: directed bench for fc_1 with behavioural BRAM models of three-cycle read latency.
// Neuron n uses weight/bias record n % 12 from the vector table; all activations are 1.0.
module tb_fc_1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fc_1_en = 1'b0;
    logic [15:0] bias_weights_bram_douta;
    logic [15:0] result_bram_douta;
    logic        bias_weights_bram_ena;
    logic [15:0] bias_weights_bram_addra;
    logic        result_bram_ena;
    logic        result_bram_wea;
    logic [12:0] result_bram_addra;
    logic [15:0] result_bram_dina;
    logic        fc_1_finish;

    fc_1 dut (
        .clk                     (clk),
        .rst                     (rst),
        .fc_1_en                 (fc_1_en),
        .bias_weights_bram_douta (bias_weights_bram_douta),
        .result_bram_douta       (result_bram_douta),
        .bias_weights_bram_ena   (bias_weights_bram_ena),
        .bias_weights_bram_addra (bias_weights_bram_addra),
        .result_bram_ena         (result_bram_ena),
        .result_bram_wea         (result_bram_wea),
        .result_bram_addra       (result_bram_addra),
        .result_bram_dina        (result_bram_dina),
        .fc_1_finish             (fc_1_finish)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] w;
        logic [15:0] b;
        logic [15:0] exp_relu;
        logic [15:0] exp_raw;
    } vec_t;

    vec_t tbl [12];

    int tests = 0;
    int fails = 0;

    logic [15:0] wmem [0:65535];
    logic [15:0] rmem [0:8191];
    logic [15:0] bw_s1, bw_s2, bw_s3;
    logic [15:0] r_s1, r_s2, r_s3;

    assign bias_weights_bram_douta = bw_s3;
    assign result_bram_douta       = r_s3;

    always @(posedge clk) begin
        if (bias_weights_bram_ena) bw_s1 <= wmem[bias_weights_bram_addra];
        bw_s2 <= bw_s1;
        bw_s3 <= bw_s2;
        if (result_bram_ena && !result_bram_wea) r_s1 <= rmem[result_bram_addra];
        if (result_bram_ena && result_bram_wea) rmem[result_bram_addra] <= result_bram_dina;
        r_s2 <= r_s1;
        r_s3 <= r_s2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          t0 = 0;
    int          wr_cnt = 0;
    int          bad_rd = 0;
    int          bad_wr = 0;
    int          bad_order = 0;
    int          last_wr = 7999;
    int          wlen = 0;
    int          wr_cyc [84];
    logic        wea_prev = 1'b0;
    logic [12:0] win_addr = '0;
    logic [15:0] win_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            last_wr  = 7999;
            wea_prev = 1'b0;
            wlen     = 0;
        end else begin
            if (bias_weights_bram_ena &&
                (bias_weights_bram_addra < 16'd50692 || bias_weights_bram_addra > 16'd60855))
                bad_rd++;
            if (result_bram_ena && !result_bram_wea &&
                (result_bram_addra < 13'd7880 || result_bram_addra > 13'd7999))
                bad_rd++;
            if (result_bram_wea && !result_bram_ena) bad_wr++;
            if (result_bram_ena && result_bram_wea) begin
                if (!wea_prev) begin
                    wr_cnt++;
                    wlen     = 0;
                    win_addr = result_bram_addra;
                    win_data = result_bram_dina;
                    if (result_bram_addra < 13'd8000 || result_bram_addra > 13'd8083) begin
                        bad_wr++;
                    end else begin
                        if (int'(result_bram_addra) != last_wr + 1) bad_order++;
                        last_wr = int'(result_bram_addra);
                        wr_cyc[int'(result_bram_addra) - 8000] = cyc - t0;
                    end
                end else if (result_bram_addra != win_addr || result_bram_dina != win_data) begin
                    bad_wr++;
                end
                wlen++;
            end else if (wea_prev) begin
                if (wlen != 3) bad_wr++;
                wlen = 0;
            end
            wea_prev = result_bram_ena && result_bram_wea;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_of(input int n);
`ifdef FC1_RELU_EN
        return tbl[n % 12].exp_relu;
`else
        return tbl[n % 12].exp_raw;
`endif
    endfunction

    task automatic wait_rel(input int k);
        while (cyc - t0 < k) @(negedge clk);
    endtask

    initial begin
        int wr_base;

        //          weight    bias      relu      raw
        tbl[0]  = '{16'h0000, 16'hFF00, 16'h0000, 16'hFF00};  // -1.0 bias only
        tbl[1]  = '{16'h0080, 16'h0000, 16'h3C00, 16'h3C00};  // 120 * 0.5 = 60.0
        tbl[2]  = '{16'h7FFF, 16'h0000, 16'h7FFF, 16'h7FFF};  // positive saturation
        tbl[3]  = '{16'h8000, 16'h0000, 16'h0000, 16'h8000};  // negative saturation
        tbl[4]  = '{16'hFFFF, 16'h0100, 16'h0088, 16'h0088};  // 256 - 120
        tbl[5]  = '{16'h0001, 16'h0000, 16'h0078, 16'h0078};
        tbl[6]  = '{16'h0100, 16'h7F00, 16'h7FFF, 16'h7FFF};  // bias + sum overflow
        tbl[7]  = '{16'hFFFE, 16'h0000, 16'h0000, 16'hFF10};  // -240
        tbl[8]  = '{16'h0011, 16'h0005, 16'h07FD, 16'h07FD};  // 5 + 2040
        tbl[9]  = '{16'h0000, 16'h0123, 16'h0123, 16'h0123};
        tbl[10] = '{16'h0100, 16'h07FF, 16'h7FFF, 16'h7FFF};  // exactly +32767
        tbl[11] = '{16'hFF00, 16'hF800, 16'h0000, 16'h8000};  // exactly -32768

        for (int a = 0; a < 8192; a++) rmem[a] = 16'h0000;
        for (int i = 0; i < 120; i++) rmem[7880 + i] = 16'h0100;
        for (int n = 0; n < 84; n++) rmem[8000 + n] = 16'hDEAD;
        for (int n = 0; n < 84; n++) begin
            wmem[60772 + n] = tbl[n % 12].b;
            for (int i = 0; i < 120; i++) wmem[50692 + n * 120 + i] = tbl[n % 12].w;
        end

        #3 rst = 1'b0;
        #1;
        check("rst_bw_ena",  bias_weights_bram_ena,   0);
        check("rst_bw_addr", bias_weights_bram_addra, 0);
        check("rst_r_ena",   result_bram_ena,         0);
        check("rst_r_wea",   result_bram_wea,         0);
        check("rst_r_addr",  result_bram_addra,       0);
        check("rst_r_dina",  result_bram_dina,        0);
        check("rst_finish",  fc_1_finish,             0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_en_low", {bias_weights_bram_ena, result_bram_ena, result_bram_wea}, 0);

        // Run 1: stall inside neuron 10's MAC loop, then reset during neuron 40's store.
        fc_1_en = 1'b1;
        t0 = cyc;
        wait_rel(2);
        check("n0_bias_ena",  bias_weights_bram_ena,   1);
        check("n0_bias_addr", bias_weights_bram_addra, 60772);
        wait_rel(6);
        check("n0_mac_waddr", bias_weights_bram_addra, 50692);
        check("n0_mac_xaddr", result_bram_addra,       7880);
        check("n0_mac_xena",  result_bram_ena,         1);
        wait_rel(492);
        check("n1_bias_addr", bias_weights_bram_addra, 60773);

        wait_rel(5146);
        check("stall_waddr", bias_weights_bram_addra, 51952);
        check("stall_xaddr", result_bram_addra,       7940);
        fc_1_en = 1'b0;
        repeat (100) @(negedge clk);
        check("frozen_waddr", bias_weights_bram_addra, 51952);
        check("frozen_xaddr", result_bram_addra,       7940);
        check("frozen_ena",   {bias_weights_bram_ena, result_bram_ena}, 2'b11);
        fc_1_en = 1'b1;

        wait_rel(20187);
        check("n40_wea",  result_bram_wea,   1);
        check("n40_addr", result_bram_addra, 8040);
        check("n40_dina", result_bram_dina,  exp_of(40));
        #2 rst = 1'b0;
        fc_1_en = 1'b0;
        #1;
        check("arst_bw_ena", bias_weights_bram_ena, 0);
        check("arst_r_ena",  result_bram_ena,       0);
        check("arst_r_wea",  result_bram_wea,       0);
        check("arst_r_addr", result_bram_addra,     0);
        check("arst_r_dina", result_bram_dina,      0);
        @(negedge clk);
        check("n40_not_written", rmem[8040], 16'hDEAD);
        for (int n = 0; n < 40; n++)
            check($sformatf("run1_out[%0d]", n), rmem[8000 + n], exp_of(n));
        check("wr_time_n0",  wr_cyc[0],  487);
        check("wr_time_n9",  wr_cyc[9],  4897);
        check("wr_time_n10", wr_cyc[10], 5487);
        check("wr_time_n39", wr_cyc[39], 19697);

        // Run 2: full uninterrupted pass from neuron 0.
        for (int n = 0; n < 84; n++) rmem[8000 + n] = 16'hDEAD;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        wr_base = wr_cnt;
        fc_1_en = 1'b1;
        t0 = cyc;
        while (!fc_1_finish && (cyc - t0) < 45000) @(negedge clk);
        check("finish_cycle", cyc - t0, 41163);
        check("done_enables", {bias_weights_bram_ena, result_bram_ena, result_bram_wea}, 0);
        for (int n = 0; n < 84; n++)
            check($sformatf("run2_out[%0d]", n), rmem[8000 + n], exp_of(n));
        check("write_count", wr_cnt - wr_base, 84);
        check("bad_reads",   bad_rd,    0);
        check("bad_writes",  bad_wr,    0);
        check("write_order", bad_order, 0);
        check("wr_time_r2_n0",  wr_cyc[0],  487);
        check("wr_time_r2_n83", wr_cyc[83], 41157);

        repeat (5) @(negedge clk);
        check("finish_hold", fc_1_finish, 1);
        fc_1_en = 1'b0;
        @(negedge clk);
        check("finish_clear", fc_1_finish, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
